sar_search: RTL and testbench

Successive-approximation search controller: the driving end of the magnitude-comparator interface. It presents a trial value to an external combinational comparator, whose other operand is a hidden target, and reads back the `more`/`less` verdict. It converges on the target one bit per cycle, MSB first. Used wherever a value is recovered by comparison only, e.g. threshold calibration against the team's 4-bit comparator.

---
 rtl/sar_search.sv | 104 ++++++++++
 tb/tb_sar_search.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sar_search.sv
// Successive-approximation search: drives a trial value into an external magnitude
// comparator and settles on the hidden target one bit per cycle, MSB first.
//
// state | meaning
// IDLE  | waiting for start, guess held at 0
// TRY   | one trial per cycle, verdict sampled on each edge
// DONE  | one-cycle completion pulse, guess returns to 0
module sar_search #(
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic [WIDTH-1:0]           guess,
  input  logic                       more,
  input  logic                       less,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           result,
  output logic [$clog2(WIDTH+1)-1:0] steps,
  output logic                       err
);

  localparam int SW = $clog2(WIDTH+1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH-1);
  localparam logic [IW-1:0]    TOP = IW'(WIDTH-1);

  typedef enum logic [1:0] {IDLE, TRY, DONE} state_t;

  state_t            state, state_nx;
  logic [IW-1:0]     idx, idx_nx;
  logic [WIDTH-1:0]  guess_nx, result_nx, trial_kept;
  logic [SW-1:0]     steps_nx;
  logic              err_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= TOP;
      guess  <= '0;
      result <= '0;
      steps  <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      guess  <= guess_nx;
      result <= result_nx;
      steps  <= steps_nx;
      err    <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    guess_nx  = guess;
    result_nx = result;
    steps_nx  = steps;
    err_nx    = err;
    // "more" means the trial overshot, so the bit under test is dropped
    trial_kept = more ? (guess & ~(WIDTH'(1) << idx)) : guess;

    case (state)
      IDLE: begin
        if (start) begin
          guess_nx  = MSB;
          idx_nx    = TOP;
          steps_nx  = '0;
          err_nx    = 1'b0;
          result_nx = '0;
          state_nx  = TRY;
        end
      end
      TRY: begin
        steps_nx = steps + SW'(1);
        if (more && less) begin
          err_nx    = 1'b1;
          result_nx = guess;
          state_nx  = DONE;
        end else if (!more && !less) begin
          result_nx = guess;
          state_nx  = DONE;
        end else if (idx != '0) begin
          guess_nx = trial_kept | (WIDTH'(1) << (idx - IW'(1)));
          idx_nx   = idx - IW'(1);
        end else begin
          result_nx = trial_kept;
          state_nx  = DONE;
        end
      end
      DONE: begin
        guess_nx = '0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == TRY);
  assign done = (state == DONE);

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: a behavioural comparator plus a binary-search model that
// predicts every cycle of guess/busy/done and the final result/steps/err.
module tb_sar_search;

  localparam int W  = 4;
  localparam int SW = $clog2(W+1);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  guess;
  logic          more;
  logic          less;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic [SW-1:0] steps;
  logic          err;

  int   target;
  logic force_both;

  int n_checks = 0;
  int n_fail   = 0;

  sar_search #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .guess  (guess),
    .more   (more),
    .less   (less),
    .busy   (busy),
    .done   (done),
    .result (result),
    .steps  (steps),
    .err    (err)
  );

  // external comparator; force_both injects the illegal both-high verdict
  assign more = force_both | (int'(guess) > target);
  assign less = force_both | (int'(guess) < target);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic busy;
    logic done;
    int   guess;
    int   result;
    int   steps;
    int   err;
  } rec_t;

  rec_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Binary search straight from the target: after deciding bits above i they
  // equal the target's, so trial i is those bits plus a 1 at position i.
  int m_tr[W];
  int m_n, m_res, m_err;

  function automatic void model(input int tgt, input int err_at);
    int k;
    m_n = W; m_res = tgt; m_err = 0;
    for (int j = 0; j < W; j++) m_tr[j] = 0;
    k = 0;
    for (int i = W-1; i >= 0; i--) begin
      int hi_mask;
      int trial;
      hi_mask = ~((1 << (i+1)) - 1);
      trial   = (tgt & hi_mask) | (1 << i);
      m_tr[k] = trial;
      k++;
      if (k == err_at) begin
        m_n = k; m_res = trial; m_err = 1;
        return;
      end
      if (trial == tgt) begin
        m_n = k; m_res = trial;
        return;
      end
    end
  endfunction

  // per-cycle compare, mid-cycle on the falling edge
  int hold_res, hold_steps, hold_err;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_res = 0; hold_steps = 0; hold_err = 0;
    end else if (exp_q.size() > 0) begin
      rec_t r;
      r = exp_q.pop_front();
      chk("busy", int'(busy), int'(r.busy));
      chk("done", int'(done), int'(r.done));
      chk("guess", int'(guess), r.guess);
      if (r.done) begin
        chk("result", int'(result), r.result);
        chk("steps", int'(steps), r.steps);
        chk("err", int'(err), r.err);
        hold_res = r.result; hold_steps = r.steps; hold_err = r.err;
      end
    end else begin
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", int'(done), 0);
      chk("idle_guess", int'(guess), 0);
      chk("held_result", int'(result), hold_res);
      chk("held_steps", int'(steps), hold_steps);
      chk("held_err", int'(err), hold_err);
    end
  end

  // Entered just after a rising edge. Starts a search, optionally forcing the
  // both-high verdict on TRY err_at, pulsing start after edge E0+pulse_at, or
  // asserting reset during TRY rst_at+1.
  task automatic run(input int tgt, input int err_at, input int pulse_at, input int rst_at);
    rec_t r;
    model(tgt, err_at);
    target = tgt;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < m_n; k++) begin
      r = '{busy: 1'b1, done: 1'b0, guess: m_tr[k], result: 0, steps: 0, err: 0};
      exp_q.push_back(r);
    end
    r = '{busy: 1'b0, done: 1'b1, guess: m_tr[m_n-1], result: m_res, steps: m_n, err: m_err};
    exp_q.push_back(r);
    force_both = (err_at == 1);
    for (int k = 1; k <= m_n + 1; k++) begin
      @(posedge clk); #1;
      start      = (k == pulse_at);
      force_both = (k + 1 == err_at);
      if (k == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_guess", int'(guess), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_steps", int'(steps), 0);
        chk("rst_err", int'(err), 0);
        start = 1'b0;
        force_both = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
    end
    start = 1'b0;
    force_both = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, elapsed %0t, limit 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    force_both = 1'b0;
    target = 0;
    #3 rst_n = 1'b0;
    #1;
    chk("reset_guess", int'(guess), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_result", int'(result), 0);
    chk("reset_steps", int'(steps), 0);
    chk("reset_err", int'(err), 0);

    // literal pins on the model itself
    model(0, 0);
    chk("model_t0_n", m_n, 4);
    chk("model_t0_res", m_res, 0);
    chk("model_t0_tr1", m_tr[1], 4);
    chk("model_t0_tr3", m_tr[3], 1);
    model(8, 0);
    chk("model_t8_n", m_n, 1);
    chk("model_t8_res", m_res, 8);
    model(15, 0);
    chk("model_t15_tr2", m_tr[2], 14);
    chk("model_t15_n", m_n, 4);
    model(5, 0);
    chk("model_t5_tr2", m_tr[2], 6);
    chk("model_t5_tr3", m_tr[3], 5);
    model(3, 2);
    chk("model_err_n", m_n, 2);
    chk("model_err_res", m_res, 4);
    chk("model_err_flag", m_err, 1);

    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    run(0, 0, 0, 0);
    run(8, 0, 0, 0);
    run(15, 0, 0, 0);
    run(5, 0, 0, 0);
    run(3, 2, 0, 0);
    run(5, 0, 2, 0);   // start pulsed mid-TRY
    run(9, 0, 4, 0);   // start pulsed during DONE
    run(0, 0, 0, 2);   // reset during 3rd TRY
    run(6, 0, 0, 0);
    run(15, 0, 0, 0);

    for (int t = 0; t < 60; t++) begin
      int tgt, ea, pa, gap;
      tgt = $urandom_range(0, (1 << W) - 1);
      model(tgt, 0);
      ea = ($urandom_range(0, 3) == 0) ? $urandom_range(1, m_n) : 0;
      model(tgt, ea);
      pa = ($urandom_range(0, 2) == 0) ? $urandom_range(1, m_n) : 0;
      run(tgt, ea, pa, 0);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
